// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its burst read controller.
package fifo_pkg;

    localparam int DEFAULT_FIFO_WIDTH = 8;
    localparam int DEFAULT_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered valid/ready buffer. The head word is held stable while stalled.
module stream_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop;
    logic             do_push;

    assign valid   = (count != 2'd0);
    assign data    = mem[rd_ptr];
    assign pop     = valid && ready;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from a 1-cycle-latency FIFO and replays them on a valid/ready stream.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_read_en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    // Stream handshake: a word moves when m_valid && m_ready at a rising edge;
    // m_valid never drops and m_data never changes while a word waits for m_ready.

    state_t               state;
    logic [LEN_WIDTH-1:0] issue_cnt;
    logic [LEN_WIDTH-1:0] rx_cnt;
    logic                 inflight;
    logic [1:0]           occ;
    logic                 pop;
    logic [2:0]           pending;

    assign pop     = m_valid && m_ready;
    // Words that will occupy the buffer after this edge if no new read is issued.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_read_en = (state == READ) && (issue_cnt != '0) && !fifo_empty
                          && (pending < 3'd2);

    assign m_last = m_valid && (rx_cnt == LEN_WIDTH'(1));

    stream_skid_buf #(
        .WIDTH(FIFO_WIDTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .push_data(fifo_data),
        .valid    (m_valid),
        .data     (m_data),
        .ready    (m_ready),
        .count    (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= fifo_read_en;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            state     <= READ;
                            busy      <= 1'b1;
                            issue_cnt <= burst_len;
                            rx_cnt    <= burst_len;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (fifo_read_en) begin
                        issue_cnt <= issue_cnt - LEN_WIDTH'(1);
                    end
                    if (pop) begin
                        rx_cnt <= rx_cnt - LEN_WIDTH'(1);
                        if (rx_cnt == LEN_WIDTH'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed and randomized bench for fifo_burst_reader with a queue-based FIFO and stream scoreboard.
module tb_fifo_burst_reader;

    localparam int W  = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          fifo_read_en;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          m_ready;

    always #5 clk = ~clk;

    fifo_burst_reader #(.FIFO_WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .fifo_read_en(fifo_read_en),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];

    // Reference: burst in progress, done expected, transfers still owed.
    logic         mdl_busy   = 1'b0;
    logic         mdl_done   = 1'b0;
    int           mdl_rem    = 0;
    int           n_popped   = 0;
    int           n_accepted = 0;
    int           n_words    = 0;
    int           n_done     = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         prev_reset = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural FIFO with one-cycle read latency.
    always @(posedge clk) begin
        if (fifo_read_en && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin : monitor
        logic         xfer;
        logic         nb;
        logic         nd;
        logic [W-1:0] junk;
        xfer = m_valid && m_ready && !reset;
        if (done === 1'b1) n_done++;
        if (!prev_reset) begin
            check("busy", busy, mdl_busy);
            check("done", done, mdl_done);
            if (!mdl_busy) check("idle_valid", m_valid, 0);
            if (m_valid) check("m_last", m_last, mdl_rem == 1);
            else check("m_last_idle", m_last, 0);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            if (fifo_read_en) check("read_on_empty", fifo_empty, 0);
        end
        if (xfer) begin
            if (exp_q.size() == 0) check("unexpected_word", 1, 0);
            else check("m_data", m_data, exp_q.pop_front());
            n_accepted++;
            n_words++;
        end
        if (fifo_read_en === 1'b1 && !fifo_empty) n_popped++;
        check("outstanding", (n_popped - n_accepted) <= 2, 1);
        if (reset) begin
            // Words already popped but never delivered are lost by the reset.
            for (int k = 0; k < n_popped - n_accepted; k++)
                if (exp_q.size() != 0) junk = exp_q.pop_front();
            n_accepted = n_popped;
            mdl_busy   = 1'b0;
            mdl_done   = 1'b0;
            mdl_rem    = 0;
            prev_stall = 1'b0;
        end else begin
            nb = mdl_busy;
            nd = 1'b0;
            if (mdl_busy) begin
                if (xfer) begin
                    mdl_rem--;
                    if (mdl_rem == 0) begin
                        nb = 1'b0;
                        nd = 1'b1;
                    end
                end
            end else if (!mdl_done && start) begin
                if (burst_len == 0) nd = 1'b1;
                else begin
                    nb      = 1'b1;
                    mdl_rem = int'(burst_len);
                end
            end
            mdl_busy   = nb;
            mdl_done   = nd;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
        prev_reset = reset;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic start_burst(input int len);
        burst_len = LW'(len);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((mdl_busy || mdl_done) && n < budget) begin
            cyc();
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic run_random(input int len);
        int n = 0;
        int w0;
        int d0;
        w0 = n_words;
        d0 = n_done;
        start_burst(len);
        while ((mdl_busy || mdl_done) && n < len * 8 + 60) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) push_word(W'($urandom));
            cyc();
            n++;
        end
        check("rand_timeout", n < len * 8 + 60, 1);
        check("rand_words", n_words - w0, len);
        check("rand_done", n_done - d0, 1);
    endtask

    logic exp_valid [7] = '{0, 0, 1, 1, 1, 0, 0};
    logic exp_last  [7] = '{0, 0, 0, 0, 1, 0, 0};
    logic exp_done  [7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin : stimulus
        int w0;
        int d0;
        int n;
        reset = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read_en", fifo_read_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        cyc();

        // Burst of three with an always-ready sink: first word two cycles after start.
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        m_ready = 1'b1;
        start_burst(3);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t1_valid", m_valid, exp_valid[k]);
            check("t1_last", m_last, exp_last[k]);
            check("t1_done", done, exp_done[k]);
            cyc();
        end
        check("t1_busy_after", busy, 0);

        // Zero-length burst: immediate done, no reads even with data waiting.
        push_word(8'hA5);
        d0 = n_done;
        start_burst(0);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_read_en", fifo_read_en, 0);
        check("t2_valid", m_valid, 0);
        cyc();
        @(negedge clk);
        check("t2_done_once", n_done - d0, 1);
        cyc();

        // FIFO starves mid-burst and refills later.
        push_word(8'hB6);
        w0 = n_words; d0 = n_done;
        start_burst(4);
        repeat (5) cyc();
        check("t3_stalled", n_words - w0, 2);
        push_word(8'hC7); push_word(8'hD8);
        wait_idle(50, "t3_timeout");
        check("t3_words", n_words - w0, 4);
        check("t3_done", n_done - d0, 1);

        // Backpressure pattern 1,0,0 with a well-stocked FIFO.
        for (int k = 0; k < 8; k++) push_word(W'(8'h40 + k));
        w0 = n_words; d0 = n_done;
        m_ready = 1'b1;
        start_burst(6);
        n = 0;
        while ((mdl_busy || mdl_done) && n < 100) begin
            m_ready = (n % 3 == 0);
            cyc();
            n++;
        end
        check("t4_timeout", n < 100, 1);
        check("t4_words", n_words - w0, 6);
        check("t4_done", n_done - d0, 1);

        // Reset after two of five words; then a one-word burst picks up the next FIFO word.
        for (int k = 0; k < 4; k++) push_word(W'(8'h60 + k));
        m_ready = 1'b1;
        w0 = n_words; d0 = n_done;
        start_burst(5);
        n = 0;
        while (n_words - w0 < 2 && n < 50) begin
            cyc();
            n++;
        end
        check("t5_reach2", n < 50, 1);
        reset = 1'b1; m_ready = 1'b0;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_read_en", fifo_read_en, 0);
        check("t5_valid", m_valid, 0);
        check("t5_last", m_last, 0);
        check("t5_data", m_data, 0);
        cyc();
        repeat (3) cyc();
        check("t5_no_done", n_done - d0, 0);
        m_ready = 1'b1;
        w0 = n_words;
        start_burst(1);
        wait_idle(30, "t5_timeout");
        check("t5_words", n_words - w0, 1);

        // Extra starts while busy are ignored.
        for (int k = 0; k < 3; k++) push_word(W'(8'h80 + k));
        w0 = n_words; d0 = n_done;
        start_burst(3);
        start_burst(7);
        wait_idle(40, "t6_timeout");
        repeat (3) cyc();
        check("t6_words", n_words - w0, 3);
        check("t6_done", n_done - d0, 1);
        check("t6_busy", busy, 0);

        // Randomized bursts, including the maximum length.
        for (int b = 0; b < 8; b++) run_random($urandom_range(1, 12));
        run_random(255);
        m_ready = 1'b1;
        repeat (3) cyc();
        check("leftover", exp_q.size(), fifo_q.size());

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the team's synchronous FIFO. On a start command it pops exactly burst_len words from the FIFO read port, handling the FIFO's one-cycle read latency. It re-presents those words on a valid/ready output stream, with last asserted on the final word. It sits between the FIFO and downstream consumers (serializers, DMA sinks) that apply backpressure.

Parameters:
FIFO_WIDTH, 8, data word width; must match the FIFO's FIFO_WIDTH
LEN_WIDTH, 8, width of burst_len and the internal word counters; maximum burst is 2^LEN_WIDTH-1 words

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle command pulse; sampled only in IDLE
burst_len  input  LEN_WIDTH  number of words to read; sampled with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the burst completes
fifo_read_en  output  1  connects to the FIFO read_en
fifo_empty  input  1  connects to the FIFO empty
fifo_data  input  FIFO_WIDTH  connects to the FIFO data_out; valid 1 cycle after an accepted read
m_valid  output  1  output stream word valid
m_data  output  FIFO_WIDTH  output stream data
m_last  output  1  marks the final word of the burst; qualified by m_valid
m_ready  input  1  downstream accept; transfer when m_valid && m_ready

Behaviour:
- Reset (synchronous, reset high at a clk edge):
  - state=IDLE; busy, done, fifo_read_en, m_valid, m_last all 0; m_data 0.
  - Buffer occupancy, in-flight flag and counters cleared.
  - A word popped from the FIFO in the reset cycle is discarded. Reset mid-burst abandons the burst with no done pulse.
- States: IDLE, READ, DONE.
- IDLE:
  - start=1 and burst_len!=0: latch issue_cnt=rx_cnt=burst_len, go to READ.
  - start=1 and burst_len==0: go to DONE (no reads issued).
  - start=1 in any other state is ignored.
- READ:
  - fifo_read_en is combinational. It is 1 iff issue_cnt!=0 && !fifo_empty && (occ + inflight - pop) < 2.
    - occ: words held in the 2-entry output buffer.
    - inflight: 1 if a read was issued in the previous cycle.
    - pop: m_valid && m_ready.
  - fifo_read_en is never asserted while fifo_empty=1. The FIFO therefore never sees a read on empty.
  - Each issued read decrements issue_cnt. Its data is captured from fifo_data in the following cycle.
  - The buffer is FIFO-ordered. m_valid = (occ!=0). m_data is the head entry and is held stable while m_valid && !m_ready.
  - m_last = m_valid && (rx_cnt==1). Each transfer decrements rx_cnt.
  - Transfer with rx_cnt==1 moves to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. A start in the DONE cycle is ignored.
- busy=1 in READ only.
- Throughput:
  - First word appears on m_valid 2 cycles after start when the FIFO is non-empty (issue in cycle after start, capture next cycle).
  - Sustained rate is 1 word/clk when the FIFO is non-empty and m_ready=1.
- Boundaries:
  - FIFO runs empty mid-burst: reads pause, the stream drains, and reading resumes when fifo_empty=0.
  - m_ready low: at most 2 words are buffered and reads stall. No word is ever lost or duplicated.
  - Simultaneous capture and pop: occupancy unchanged, order preserved.
  - Counters never wrap; burst_len=2^LEN_WIDTH-1 is legal.

Decomposition:
- Package fifo_pkg: state enum (IDLE, READ, DONE), default FIFO_WIDTH/LEN_WIDTH constants shared with the FIFO.
- One sub-module, stream_skid_buf: a 2-entry valid/ready buffer with a push port and a count output. The top keeps the FSM, counters and read-issue logic.

Test Plan:
1. FIFO preloaded with 0x11,0x22,0x33; start, burst_len=3, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles from start+2; m_last only on 0x33; done pulses the cycle after; busy low after.
2. burst_len=0 -> no fifo_read_en; done pulses 1 cycle after start; m_valid never asserted.
3. FIFO holds 2 words, burst_len=4; push 2 more after 5 cycles -> 4 words in order; fifo_read_en never high while fifo_empty=1; m_last on the 4th word.
4. burst_len=6, FIFO full, m_ready toggles 1,0,0,1,... -> m_data stable while stalled; the FIFO pops at most 2 words beyond those accepted; all 6 words delivered exactly once.
5. Reset asserted mid-burst after 2 of 5 words -> next cycle all outputs 0, no done pulse; a new start with burst_len=1 reads the correct next word.
6. start pulsed again while busy -> ignored; exactly burst_len words and one done pulse.
